dram_arbiter: RTL and testbench

Two-requester arbiter that shares the simple dual-port data RAM (one write port, one registered read port) between the CPU and the DMA engine. The CPU has fixed priority. A wait counter guarantees the DMA a grant after a bounded number of lost conflicts. Read data is routed back to whichever requester issued the read, one cycle after its grant. The block sits between the CPU/DMA load-store paths and the RAM's w_addr/din/w_en/r_addr/r_en/dout ports.

---
 rtl/dram_arbiter.sv | 81 ++++++++
 tb/tb_dram_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// CPU/DMA arbiter for a simple dual-port data RAM.
// Read and write ports are arbitrated separately; the DMA wins after max_wait losses.
module dram_arbiter #(
  parameter int addr_width = 11,
  parameter int data_width = 8,
  parameter int max_wait   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [addr_width-1:0] cpu_addr,
  input  logic [data_width-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [data_width-1:0] cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [addr_width-1:0] dma_addr,
  input  logic [data_width-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [data_width-1:0] dma_rdata,
  output logic [addr_width-1:0] ram_w_addr,
  output logic [data_width-1:0] ram_din,
  output logic                  ram_w_en,
  output logic [addr_width-1:0] ram_r_addr,
  output logic                  ram_r_en,
  input  logic [data_width-1:0] ram_dout
);

  logic [3:0] wait_cnt;
  logic       rd_pending;
  logic       rd_owner;
  logic       dma_pri;
  logic       cpu_rd, cpu_wr, dma_rd, dma_wr;
  logic       cpu_rd_g, cpu_wr_g, dma_rd_g, dma_wr_g;

  assign dma_pri = (wait_cnt == 4'(max_wait));

  assign cpu_rd = cpu_req & ~cpu_we;
  assign cpu_wr = cpu_req &  cpu_we;
  assign dma_rd = dma_req & ~dma_we;
  assign dma_wr = dma_req &  dma_we;

  // Only a same-kind collision is a conflict; the other port stays free.
  assign cpu_rd_g = ~rst & cpu_rd & ~(dma_rd &  dma_pri);
  assign cpu_wr_g = ~rst & cpu_wr & ~(dma_wr &  dma_pri);
  assign dma_rd_g = ~rst & dma_rd & ~(cpu_rd & ~dma_pri);
  assign dma_wr_g = ~rst & dma_wr & ~(cpu_wr & ~dma_pri);

  assign cpu_gnt = cpu_rd_g | cpu_wr_g;
  assign dma_gnt = dma_rd_g | dma_wr_g;

  assign ram_w_en   = cpu_wr_g | dma_wr_g;
  assign ram_w_addr = dma_wr_g ? dma_addr  : cpu_addr;
  assign ram_din    = dma_wr_g ? dma_wdata : cpu_wdata;
  assign ram_r_en   = cpu_rd_g | dma_rd_g;
  assign ram_r_addr = dma_rd_g ? dma_addr  : cpu_addr;

  assign cpu_rvalid = rd_pending & ~rd_owner;
  assign dma_rvalid = rd_pending &  rd_owner;
  assign cpu_rdata  = ram_dout;
  assign dma_rdata  = ram_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= '0;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      rd_pending <= ram_r_en;
      rd_owner   <= dma_rd_g;
      if (dma_gnt)
        wait_cnt <= '0;
      else if (dma_req && !dma_pri)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter with a behavioural RAM and reference model.
// Driver predicts grants and read returns; a monitor checks rvalid/rdata.
module tb_dram_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic [AW-1:0] ram_w_addr, ram_r_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic          ram_w_en, ram_r_en;

  dram_arbiter #(.addr_width(AW), .data_width(DW), .max_wait(MW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_w_addr(ram_w_addr), .ram_din(ram_din), .ram_w_en(ram_w_en),
    .ram_r_addr(ram_r_addr), .ram_r_en(ram_r_en), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [2**AW];
  always @(posedge clk) begin
    if (ram_w_en) ram[ram_w_addr] <= ram_din;
    if (ram_r_en) ram_dout <= ram[ram_r_addr];
  end

  typedef struct {
    bit          dma;
    logic [DW-1:0] data;
    int          due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mem [2**AW];
  int            mwait;
  int            cyc;
  int            n_chk;
  int            n_fail;
  bit            mon_on;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // One request cycle: drive, predict from the arbitration rules, compare grants.
  task automatic step(input bit r,
                      input bit cq, input bit cw, input int ca, input int cd,
                      input bit dq, input bit dw, input int da, input int dd);
    bit conf, dma_first, eg_c, eg_d;
    @(negedge clk);
    rst = r;
    cpu_req = cq; cpu_we = cw; cpu_addr = AW'(ca); cpu_wdata = DW'(cd);
    dma_req = dq; dma_we = dw; dma_addr = AW'(da); dma_wdata = DW'(dd);
    #1;
    conf      = cq && dq && (cw == dw);
    dma_first = (mwait >= MW);
    eg_c = !r && cq && !(conf && dma_first);
    eg_d = !r && dq && !(conf && !dma_first);
    chk("cpu_gnt", cpu_gnt, eg_c);
    chk("dma_gnt", dma_gnt, eg_d);
    chk("ram_w_en", ram_w_en, (eg_c && cw) || (eg_d && dw));
    chk("ram_r_en", ram_r_en, (eg_c && !cw) || (eg_d && !dw));
    if (eg_c && !cw) q.push_back('{1'b0, mem[AW'(ca)], cyc + 1});
    if (eg_d && !dw) q.push_back('{1'b1, mem[AW'(da)], cyc + 1});
    if (eg_c && cw) mem[AW'(ca)] = DW'(cd);
    if (eg_d && dw) mem[AW'(da)] = DW'(dd);
    if (r || eg_d) mwait = 0;
    else if (dq && mwait < MW) mwait++;
  endtask

  task automatic idle(input bit r);
    step(r, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      bit ec, ed;
      ec = q.size() > 0 && q[0].due == cyc && !q[0].dma;
      ed = q.size() > 0 && q[0].due == cyc &&  q[0].dma;
      chk("cpu_rvalid", cpu_rvalid, ec);
      chk("dma_rvalid", dma_rvalid, ed);
      if (ec) chk("cpu_rdata", cpu_rdata, q[0].data);
      if (ed) chk("dma_rdata", dma_rdata, q[0].data);
      if (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      ram[i] = '0;
      mem[i] = '0;
    end
    cyc = 0; n_chk = 0; n_fail = 0; mwait = 0;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    @(posedge clk);
    mon_on = 1'b1;

    // reset held with both requesting
    step(1, 1, 0, 1, 0, 1, 0, 2, 0);
    step(1, 1, 1, 1, 9, 1, 1, 2, 9);

    // parallel write + read of the same address
    step(0, 1, 1, 'h010, 'hA5, 1, 0, 'h010, 0);
    step(0, 1, 0, 'h010, 0, 0, 0, 0, 0);

    // read conflict for six cycles
    for (int i = 0; i < 6; i++) step(0, 1, 0, 'h001, 0, 1, 0, 'h002, 0);
    step(0, 0, 0, 0, 0, 1, 0, 'h002, 0);

    // write conflict, then DMA alone, then read back
    step(0, 1, 1, 'h7FF, 'h11, 1, 1, 'h7FF, 'h22);
    step(0, 1, 0, 'h7FF, 0, 1, 1, 'h7FF, 'h22);
    step(0, 1, 0, 'h7FF, 0, 0, 0, 0, 0);

    // preload and alternating back-to-back reads
    for (int i = 0; i < 4; i++) step(0, 1, 1, i, 'h10 + i, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      if (i % 2 == 0) step(0, 1, 0, i, 0, 0, 0, 0, 0);
      else            step(0, 0, 0, 0, 0, 1, 0, i, 0);

    // reset the cycle after a read grant
    step(0, 1, 0, 'h002, 0, 0, 0, 0, 0);
    step(1, 1, 0, 'h003, 0, 1, 0, 'h001, 0);
    idle(0);

    // randomized traffic on a small address window
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 39) == 0,
           1'($urandom), 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 255),
           1'($urandom), 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 255));
    idle(0);
    idle(0);

    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
